// File: rtl/program_loader_store.sv
// Program store for the 8-bit core: loads bytes over valid/ready, then serves instruction = mem[PC] while running.
// Optional CHECKSUM_EN macro builds a mod-256 byte accumulator on the checksum output.
module program_loader_store #(
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned ADDR_W     = 8,
    parameter logic [7:0]  IDLE_INSTR = 8'h00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mode_load,
    input  logic              load_valid,
    input  logic [7:0]        load_data,
    output logic              load_ready,
    input  logic              load_end,
    input  logic [7:0]        PC,
    output logic [7:0]        instruction,
    output logic              cpu_reset,
    output logic [ADDR_W:0]   prog_len,
    output logic [1:0]        state,
    output logic [7:0]        checksum
);

    localparam int unsigned LEN_W = ADDR_W + 1;
    localparam int unsigned CMP_W = 9;
    localparam logic [LEN_W-1:0] FULL = LEN_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_RUN  = 2'b10
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [LEN_W-1:0] wr_ptr_q;
    logic             xfer_c;
    logic             clr_c;
    logic             run_hit_c;
    logic [7:0]       mem [DEPTH];

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, handshake and load-entry clear
    always_comb begin
        state_d    = state_q;
        clr_c      = 1'b0;
        load_ready = 1'b0;
        xfer_c     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mode_load) begin
                    state_d = ST_LOAD;
                    clr_c   = 1'b1;
                end else if (wr_ptr_q != '0) begin
                    state_d = ST_RUN;
                end
            end
            ST_LOAD: begin
                load_ready = (wr_ptr_q != FULL);
                xfer_c     = load_valid & load_ready;
                // A byte accepted alongside load_end still counts toward a non-empty program
                if (load_end) begin
                    state_d = ((wr_ptr_q != '0) || xfer_c) ? ST_RUN : ST_IDLE;
                end
            end
            ST_RUN: begin
                if (mode_load) begin
                    state_d = ST_LOAD;
                    clr_c   = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Write pointer doubles as the loaded-length counter; it saturates at DEPTH
    always_ff @(posedge clk) begin
        if (reset || clr_c) begin
            wr_ptr_q <= '0;
        end else if (xfer_c) begin
            wr_ptr_q <= wr_ptr_q + LEN_W'(1);
        end
    end

    // Program storage, never cleared; the length gate hides stale bytes
    always_ff @(posedge clk) begin
        if (!reset && xfer_c) begin
            mem[wr_ptr_q[ADDR_W-1:0]] <= load_data;
        end
    end

    assign run_hit_c = (state_q == ST_RUN) && (CMP_W'(PC) < CMP_W'(wr_ptr_q));

    always_comb begin
        instruction = IDLE_INSTR;
        if (run_hit_c) begin
            instruction = mem[PC[ADDR_W-1:0]];
        end
    end

    assign cpu_reset = (state_q != ST_RUN);
    assign prog_len  = wr_ptr_q;
    assign state     = state_q;

`ifdef CHECKSUM_EN
    logic [7:0] sum_q;

    always_ff @(posedge clk) begin
        if (reset || clr_c) begin
            sum_q <= 8'h00;
        end else if (xfer_c) begin
            sum_q <= sum_q + load_data;
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = 8'h00;
`endif

endmodule
